// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave is the unit's view; master is the CPU + memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic        mem_writeEnable;
    logic [31:0] mem_writeInput;
    logic [31:0] mem_readResult;

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata, mem_readResult,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_writeEnable, mem_writeInput
    );

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata, mem_readResult,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_writeEnable, mem_writeInput
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding request to a word-addressed
// data memory with 1-cycle registered read; sub-word stores are RMW.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input logic             clock,
    input logic             reset,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_addr;
    logic [31:0] wword;
    logic [31:0] rdata_q;
    logic        error_q;

    logic        accept;
    logic        req_err;
    logic [4:0]  lane_sh;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] lane_ins;
    logic [31:0] merged;

    assign accept = bus.req_valid && (state == IDLE);

    // Request legality, checked in priority order at acceptance.
    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == 2'd3)
            req_err = 1'b1;
        else if (bus.req_size == 2'd1 && bus.req_addr[0])
            req_err = 1'b1;
        else if (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        else if (bus.req_addr >= MEM_BYTES)
            req_err = 1'b1;
    end

    // Lane extraction / extension for loads and lane merge for stores.
    always_comb begin
        lane_sh   = {lat_addr[1:0], 3'b000};
        shifted   = bus.mem_readResult >> lane_sh;
        load_val  = bus.mem_readResult;
        lane_mask = 32'h0000_00ff;
        unique case (lat_size)
            2'd0: load_val = {{24{shifted[7] & lat_signed}},
                              shifted[7:0]};
            2'd1: load_val = {{16{shifted[15] & lat_signed}},
                              shifted[15:0]};
            default: load_val = bus.mem_readResult;
        endcase
        if (lat_size == 2'd1)
            lane_mask = 32'h0000_ffff;
        lane_ins  = (wword & lane_mask) << lane_sh;
        lane_mask = lane_mask << lane_sh;
        merged    = (bus.mem_readResult & ~lane_mask) | lane_ins;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nx = RESP;
                    else if (bus.req_write && bus.req_size == 2'd2)
                        state_nx = WRITE;
                    else
                        state_nx = READ;
                end
            end
            READ:    state_nx = CAPTURE;
            CAPTURE: state_nx = lat_write ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, load result and store word datapath.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lat_write  <= 1'b0;
            lat_size   <= 2'd0;
            lat_signed <= 1'b0;
            lat_addr   <= 32'd0;
            wword      <= 32'd0;
            rdata_q    <= 32'd0;
            error_q    <= 1'b0;
        end else if (accept) begin
            lat_write  <= bus.req_write;
            lat_size   <= bus.req_size;
            lat_signed <= bus.req_signed;
            lat_addr   <= bus.req_addr;
            wword      <= bus.req_wdata;
            error_q    <= req_err;
        end else if (state == CAPTURE) begin
            if (lat_write)
                wword <= merged;
            else
                rdata_q <= load_val;
        end
    end

    assign bus.req_ready       = (state == IDLE);
    assign bus.resp_valid      = (state == RESP);
    assign bus.resp_rdata      = rdata_q;
    assign bus.resp_error      = error_q;
    assign bus.mem_writeEnable = (state == WRITE);
    assign bus.mem_writeInput  = (state == WRITE) ? wword : 32'd0;
    assign bus.mem_address     = (state == READ || state == CAPTURE ||
                                  state == WRITE)
                                 ? {lat_addr[31:2], 2'b00} : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table driven through a
// scoreboard, plus reset sequences; memory is modelled here.
module tb_load_store_unit;

    logic clock;
    logic reset;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_BYTES(4096)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_wword;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } sb_t;

    sb_t         sb[$];
    vec_t        tbl[21];
    int          total;
    int          bad;
    int          cyc;
    int          we_cnt;
    int          act_cnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    logic [31:0] dmem[1024];
    logic [31:0] rdq;

    assign bus.mem_readResult = rdq;

    // Memory: registered read, no read during a write cycle.
    always @(posedge clock) begin
        if (bus.mem_writeEnable)
            dmem[bus.mem_address[11:2]] <= bus.mem_writeInput;
        else
            rdq <= dmem[bus.mem_address[11:2]];
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on responses, counts memory activity.
    always @(negedge clock) begin
        if (bus.mem_writeEnable) begin
            we_cnt++;
            wr_addr = bus.mem_address;
            wr_data = bus.mem_writeInput;
        end
        if (bus.mem_address != 32'd0)
            act_cnt++;
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_error", {31'd0, bus.resp_error},
                    {31'd0, e.err});
                chk("latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    function automatic vec_t mk(logic wr, logic [1:0] sz, logic sg,
                                logic [31:0] addr, logic [31:0] wd,
                                logic [31:0] er, logic ee, int el,
                                int ew, logic [31:0] eww);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr;
        v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        v.exp_lat = el; v.exp_we = ew; v.exp_wword = eww;
        return v;
    endfunction

    task automatic drive(vec_t v);
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready === 1'b1) break;
            @(negedge clock);
        end
        bus.req_valid  = 1'b1;
        bus.req_write  = v.wr;
        bus.req_size   = v.sz;
        bus.req_signed = v.sg;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
    endtask

    task automatic run(vec_t v);
        int b_we;
        int b_act;
        sb_t e;
        drive(v);
        b_we  = we_cnt;
        b_act = act_cnt;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.lat   = v.exp_lat;
        e.acc   = cyc;
        sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            chk("resp_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        chk("we_pulses", we_cnt - b_we, v.exp_we);
        if (v.exp_err)
            chk("no_mem_access", act_cnt - b_act, 0);
        if (v.exp_we != 0) begin
            chk("wr_addr", wr_addr, {v.addr[31:2], 2'b00});
            chk("wr_data", wr_data, v.exp_wword);
        end
    endtask

    initial begin
        vec_t rv;
        int   b_we;
        total = 0; bad = 0; cyc = 0;
        we_cnt = 0; act_cnt = 0;
        wr_addr = 0; wr_data = 0;
        rdq = 0;
        for (int i = 0; i < 1024; i++) dmem[i] = 32'd0;
        bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0;
        bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0;

        tbl[0]  = mk(1, 2, 0, 32'h10, 32'hDEADBEEF,
                     32'h0, 0, 2, 1, 32'hDEADBEEF);
        tbl[1]  = mk(0, 2, 0, 32'h10, 32'h0,
                     32'hDEADBEEF, 0, 3, 0, 32'h0);
        tbl[2]  = mk(1, 0, 0, 32'h11, 32'hFFFFFF5A,
                     32'hDEADBEEF, 0, 4, 1, 32'hDEAD5AEF);
        tbl[3]  = mk(0, 2, 0, 32'h10, 32'h0,
                     32'hDEAD5AEF, 0, 3, 0, 32'h0);
        tbl[4]  = mk(1, 2, 0, 32'h10, 32'h80011234,
                     32'hDEAD5AEF, 0, 2, 1, 32'h80011234);
        tbl[5]  = mk(0, 0, 1, 32'h13, 32'h0,
                     32'hFFFFFF80, 0, 3, 0, 32'h0);
        tbl[6]  = mk(0, 0, 0, 32'h13, 32'h0,
                     32'h00000080, 0, 3, 0, 32'h0);
        tbl[7]  = mk(0, 1, 1, 32'h12, 32'h0,
                     32'hFFFF8001, 0, 3, 0, 32'h0);
        tbl[8]  = mk(0, 1, 0, 32'h12, 32'h0,
                     32'h00008001, 0, 3, 0, 32'h0);
        tbl[9]  = mk(0, 0, 1, 32'h10, 32'h0,
                     32'h00000034, 0, 3, 0, 32'h0);
        tbl[10] = mk(1, 1, 0, 32'h12, 32'h1234BEEF,
                     32'h00000034, 0, 4, 1, 32'hBEEF1234);
        tbl[11] = mk(0, 1, 1, 32'h10, 32'h0,
                     32'h00001234, 0, 3, 0, 32'h0);
        tbl[12] = mk(0, 2, 0, 32'h10, 32'h0,
                     32'hBEEF1234, 0, 3, 0, 32'h0);
        tbl[13] = mk(0, 1, 0, 32'h01, 32'h0,
                     32'hBEEF1234, 1, 1, 0, 32'h0);
        tbl[14] = mk(1, 2, 0, 32'h02, 32'h11111111,
                     32'hBEEF1234, 1, 1, 0, 32'h0);
        tbl[15] = mk(0, 3, 0, 32'h10, 32'h0,
                     32'hBEEF1234, 1, 1, 0, 32'h0);
        tbl[16] = mk(0, 2, 0, 32'h1000, 32'h0,
                     32'hBEEF1234, 1, 1, 0, 32'h0);
        tbl[17] = mk(1, 2, 0, 32'hFFC, 32'hCAFEF00D,
                     32'hBEEF1234, 0, 2, 1, 32'hCAFEF00D);
        tbl[18] = mk(0, 1, 1, 32'hFFE, 32'h0,
                     32'hFFFFCAFE, 0, 3, 0, 32'h0);
        tbl[19] = mk(1, 0, 0, 32'h23, 32'h000000AB,
                     32'hFFFFCAFE, 0, 4, 1, 32'hAB000000);
        tbl[20] = mk(0, 2, 0, 32'h20, 32'h0,
                     32'hAB000000, 0, 3, 0, 32'h0);

        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
        chk("rst_mem_address", bus.mem_address, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_writeEnable}, 32'd0);
        chk("rst_mem_wi", bus.mem_writeInput, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("req_ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 21; i++) run(tbl[i]);

        // Reset sampled at the end of CAPTURE of a byte store.
        rv = mk(1, 0, 0, 32'h10, 32'h77, 0, 0, 0, 0, 0);
        drive(rv);
        b_we = we_cnt;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rstcap_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rstcap_rdata", bus.resp_rdata, 32'd0);
        chk("rstcap_mem_address", bus.mem_address, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rstcap_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rstcap_no_write", we_cnt - b_we, 0);
        chk("rstcap_mem_word", dmem[4], 32'hBEEF1234);
        run(mk(0, 2, 0, 32'h10, 32'h0,
               32'hBEEF1234, 0, 3, 0, 32'h0));

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts single load/store requests from the CPU datapath and drives the word-addressed data memory.
- The data memory has a registered read (1-cycle latency) and does not read in a write cycle.
- Byte and halfword stores run as read-modify-write. Loads are extracted, then sign- or zero-extended.
- Sits between the execute stage and the data memory. One request is outstanding at a time.

Parameters:
- MEM_BYTES, 4096, size of the addressed data memory in bytes (1024 words). An address >= MEM_BYTES is an error.

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle; a request is accepted when req_valid & req_ready at a rising edge
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result, held until the next resp_valid
- resp_error  output  1  qualifies resp_valid: misaligned, illegal size or out-of-range
- mem_address  output  32  to data memory; always word-aligned ({addr[31:2],2'b00})
- mem_writeEnable  output  1  to data memory
- mem_writeInput  output  32  to data memory
- mem_readResult  input  32  from data memory; valid the cycle after a read cycle

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - resp_valid, resp_rdata, resp_error, mem_address, mem_writeEnable and mem_writeInput all become 0.
  - req_ready is 1 from the first cycle after reset.
- Memory outputs are decoded from registered state, so the memory samples whatever the unit drove in the cycle that reset was sampled. A WRITE cycle coincident with reset therefore still commits. Nothing is issued afterwards, and no resp_valid is produced for the aborted request.
- Byte-lane ordering is little-endian: addr[1:0]==0 selects bits [7:0]; a halfword at addr[1]==1 selects bits [31:16].
- The request is latched on acceptance. Inputs are ignored outside IDLE.
- Error checks at acceptance, in this order:
  - size==3
  - halfword with addr[0]!=0
  - word with addr[1:0]!=0
  - addr >= MEM_BYTES
- On error: go to RESP with resp_error=1 and resp_rdata unchanged. No memory access is made.
- States (cycle 0 = accept edge):
  - IDLE: req_ready=1, mem_writeEnable=0.
    - Load goes to READ.
    - Word store goes to WRITE.
    - Byte or halfword store goes to READ.
    - Error goes to RESP.
  - READ: mem_address = latched address, mem_writeEnable=0; memory registers the word at the end of this cycle. Next state is CAPTURE.
  - CAPTURE: sample mem_readResult.
    - Load: extract the lane, extend per req_signed, write resp_rdata, go to RESP.
    - Store: merge the new byte/halfword into the read word, keeping other lanes untouched, and go to WRITE.
  - WRITE: mem_writeEnable=1, mem_writeInput = final word, mem_address held. Next state is RESP.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0. Next state is IDLE.
- Latency, as resp_valid cycle after accept:
  - error: cycle 1
  - word store: cycle 2
  - load: cycle 3
  - sub-word store: cycle 4
- Back-to-back: a new request can be accepted in the cycle after RESP. A load after a store observes the stored data.
- mem_writeEnable is high only in WRITE, and for exactly one cycle per store.

Test Plan:
- Reset low for 2 cycles, then high → all outputs 0, req_ready=1 the cycle after release.
- Word store 0xDEADBEEF @0x10, then word load @0x10 → one WE pulse with address 0x10 and data 0xDEADBEEF; load resp_valid at cycle 3 with rdata 0xDEADBEEF, resp_error=0.
- Byte store 0x5A @0x11 over word 0xDEADBEEF → READ, then a write of 0xDEAD5AEF; resp_valid at cycle 4.
- Loads @0x13:
  - signed byte, word 0x80xxxxxx → 0xFFFFFF80
  - unsigned byte → 0x00000080
  - signed halfword @0x12 on 0x8001xxxx → 0xFFFF8001
- Errors, each giving resp_error=1 at cycle 1 with no WE and no read:
  - halfword @0x01
  - word @0x02
  - size=3
  - word @0x1000
- Reset asserted during CAPTURE of a byte store → no write issued, no resp_valid; memory word unchanged.
